temp_fan_ctrl: RTL and testbench
================================

Name: temp_fan_ctrl

Overview:
- Avalon-MM slave in FPGA fabric, mastered by the HPS lightweight bridge of soc_system.
- Consumes that bridge's read/write traffic.
- Periodically reads the board temperature sensor (ADT7301, SPI: TEMP_CS_n/TEMP_SCLK/TEMP_DIN/TEMP_DOUT) and exposes the result to software.
- Drives FAN_CTRL with a hysteresis thermostat plus a software override.

Parameters:
- CLK_DIV, 25: clk cycles per SCLK half-period; SCLK = clk/(2*CLK_DIV), 1 MHz at 50 MHz.
- POLL_CYCLES, 50000000: clk cycles between conversion starts while polling is enabled.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- avs_address  in  2  word address.
- avs_read  in  1  read strobe.
- avs_readdata  out  32  read data, valid one cycle after avs_read.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- temp_cs_n  out  1  sensor chip select, active low.
- temp_sclk  out  1  sensor SPI clock.
- temp_din  out  1  sensor data in.
- temp_dout  in  1  sensor data out.
- fan_ctrl  out  1  fan enable, 1 = on.

Behaviour:
- Reset values:
  - temp_cs_n=1, temp_sclk=1, temp_din=0, avs_readdata=0, fan_ctrl=1.
  - TEMP=0 with valid=0; CTRL=0x5; ON_TH=0x0A00 (80 °C); OFF_TH=0x0780 (60 °C); sample count=0; poll counter=0; FSM in IDLE.
- Register map (word address):
  - 0 TEMP (RO): [13:0] last temperature, two's complement, 1/32 °C per LSB; [31] valid. Other bits 0.
  - 1 CTRL (RW): [0] poll_en; [1] fan_force; [2] auto_en. Other bits read 0.
  - 2 THRESH (RW): [13:0] ON_TH; [29:16] OFF_TH. Other bits read 0.
  - 3 STATUS (RO): [0] busy (FSM not IDLE); [1] fan_state; [15:8] sample_count (8-bit, wraps 255→0).
- Bus timing:
  - No waitrequest.
  - Read latency fixed at 1 cycle: avs_readdata is registered.
  - Writes take effect on the cycle after avs_write.
  - Writes to RO registers are ignored.
  - Simultaneous read and write to the same address returns the old value.
- Poll counter:
  - Held at 0 while poll_en=0.
  - Otherwise increments in IDLE; reaching POLL_CYCLES-1 starts a transfer and clears the counter.
  - Counter is frozen while busy.
- FSM states: IDLE → CS_SETUP → SHIFT → CS_HOLD → IDLE.
  - CS_SETUP: temp_cs_n=0, sclk=1 for CLK_DIV cycles.
  - SHIFT: 16 bits, MSB first, SPI mode 3.
    - sclk falls for CLK_DIV cycles, then rises for CLK_DIV cycles.
    - temp_dout is sampled on the clk cycle in which sclk rises.
    - temp_din=0 throughout (normal-mode command).
  - CS_HOLD: after the 16th rising edge, sclk=1, cs_n=1 for CLK_DIV cycles.
    - On entry, latch shift[13:0] into TEMP, set valid=1, increment sample_count.
  - Back in IDLE, return to idle levels.
- Clearing poll_en mid-transfer: the transfer completes and its result is latched; no new transfer starts.
- Thermostat: evaluated on the cycle after each TEMP latch, using signed 14-bit compares.
  - auto_en=1 and TEMP >= ON_TH → fan_state=1.
  - auto_en=1 and TEMP <= OFF_TH → fan_state=0.
  - Otherwise fan_state holds. If OFF_TH >= ON_TH, the ON compare wins.
  - fan_state resets to 1 and stays 1 until the first valid sample.
- fan_ctrl output:
  - Registered: fan_ctrl = fan_force | (auto_en & fan_state).
  - fan_force and auto_en both 0 → fan off.
- Reset mid-transfer: synchronous reset immediately returns all state, including the FSM and SPI pins, to reset values. No partial result is latched.

Test Plan:
- Reset check (CLK_DIV=2, POLL_CYCLES=100): hold reset 3 cycles, release.
  - Expect fan_ctrl=1, cs_n=1, sclk=1.
  - Read addr 1 → 0x5; addr 2 → 0x07800A00; addr 0 → 0x0.
  - First cs_n fall at cycle 100 after reset release.
- Sensor model returns 0x0C80 (100 °C).
  - Expect exactly 16 sclk rising edges, each half-period 2 clk cycles.
  - TEMP read → 0x80000C80; STATUS[15:8]=1; fan_ctrl=1.
- Hysteresis with auto_en=1: samples 0x0A00, 0x0900, 0x0780, 0x0900, 0x0A00.
  - fan_state sequence: 1, 1, 0, 0, 1.
- Negative temperature: sample 0x3FE0 (−1 °C), ON_TH=0x0A00.
  - Signed compare turns the fan off (−1 <= 60 °C).
  - TEMP reads 0x80003FE0.
- Override and disable:
  - Write CTRL=0x2 → fan_ctrl=1 regardless of temperature.
  - Write CTRL=0x0 → fan_ctrl=0.
  - Write poll_en=0 mid-SHIFT → the transfer completes, the count increments once, and no further cs_n falls occur in 3×POLL_CYCLES.
- Reset during SHIFT at bit 7:
  - cs_n=1 and sclk=1 the cycle after reset.
  - TEMP stays 0, valid=0; the next transfer is a full 16 bits.

Source files
------------

// File: rtl/temp_fan_ctrl.sv
// temp_fan_ctrl: Avalon-MM slave that polls an ADT7301 temperature sensor
// over SPI (mode 3) and drives a fan enable from a hysteresis thermostat
// with a software override.
//
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   avs_address/read/write  Avalon-MM slave, word addressed, no waitrequest
//   avs_writedata           write data
//   avs_readdata            registered read data, valid one cycle after read
//   temp_cs_n/sclk/din      SPI outputs to the sensor
//   temp_dout               SPI data from the sensor
//   fan_ctrl                fan enable, 1 = on
//
// Register map: 0 TEMP (RO), 1 CTRL (RW), 2 THRESH (RW), 3 STATUS (RO).
module temp_fan_ctrl #(
    parameter int CLK_DIV     = 25,
    parameter int POLL_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic        temp_cs_n,
    output logic        temp_sclk,
    output logic        temp_din,
    input  logic        temp_dout,
    output logic        fan_ctrl
);

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int PW = $clog2(POLL_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD} state_t;

    state_t          state;
    logic [DW-1:0]   div_cnt;
    logic [3:0]      bit_cnt;
    logic [15:0]     shift_reg;
    logic [PW-1:0]   poll_cnt;
    logic [13:0]     temp_val;
    logic            temp_valid;
    logic [7:0]      sample_cnt;
    logic            fan_state;
    logic            eval_pend;

    logic            poll_en;
    logic            fan_force;
    logic            auto_en;
    logic [13:0]     on_th;
    logic [13:0]     off_th;

    logic            div_done;
    logic            busy;

    assign div_done = (div_cnt == DW'(CLK_DIV - 1));
    assign busy     = (state != IDLE);

    // Normal-mode command: the sensor input is never driven high.
    assign temp_din = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{avs_writedata[31:30], avs_writedata[15:14], shift_reg[15:14]};

    // Sequencer, SPI pins, sample capture and thermostat.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            temp_cs_n  <= 1'b1;
            temp_sclk  <= 1'b1;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            poll_cnt   <= '0;
            temp_val   <= '0;
            temp_valid <= 1'b0;
            sample_cnt <= '0;
            fan_state  <= 1'b1;
            eval_pend  <= 1'b0;
        end else begin
            eval_pend <= 1'b0;

            // Thermostat runs one cycle after a capture; ON wins if the
            // thresholds overlap.
            if (eval_pend && auto_en) begin
                if ($signed(temp_val) >= $signed(on_th))
                    fan_state <= 1'b1;
                else if ($signed(temp_val) <= $signed(off_th))
                    fan_state <= 1'b0;
            end

            case (state)
                IDLE: begin
                    temp_cs_n <= 1'b1;
                    temp_sclk <= 1'b1;
                    div_cnt   <= '0;
                    bit_cnt   <= '0;
                    if (!poll_en) begin
                        poll_cnt <= '0;
                    end else if (poll_cnt == PW'(POLL_CYCLES - 1)) begin
                        poll_cnt  <= '0;
                        temp_cs_n <= 1'b0;
                        state     <= CS_SETUP;
                    end else begin
                        poll_cnt <= poll_cnt + 1'b1;
                    end
                end

                CS_SETUP: begin
                    if (div_done) begin
                        div_cnt   <= '0;
                        temp_sclk <= 1'b0;
                        state     <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                // Each bit: CLK_DIV cycles low, then CLK_DIV cycles high.
                // Data is captured on the cycle sclk is driven high.
                SHIFT: begin
                    if (!div_done) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (!temp_sclk) begin
                            temp_sclk <= 1'b1;
                            shift_reg <= {shift_reg[14:0], temp_dout};
                        end else if (bit_cnt == 4'd15) begin
                            temp_cs_n  <= 1'b1;
                            temp_val   <= shift_reg[13:0];
                            temp_valid <= 1'b1;
                            sample_cnt <= sample_cnt + 1'b1;
                            eval_pend  <= 1'b1;
                            state      <= CS_HOLD;
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            temp_sclk <= 1'b0;
                        end
                    end
                end

                CS_HOLD: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // Bus registers, read mux and fan output.
    always_ff @(posedge clk) begin
        if (reset) begin
            avs_readdata <= '0;
            poll_en      <= 1'b1;
            fan_force    <= 1'b0;
            auto_en      <= 1'b1;
            on_th        <= 14'h0A00;
            off_th       <= 14'h0780;
            fan_ctrl     <= 1'b1;
        end else begin
            fan_ctrl <= fan_force | (auto_en & fan_state);

            // Read samples pre-write values, so a same-cycle write is
            // visible only on a later read.
            if (avs_read) begin
                case (avs_address)
                    2'd0: avs_readdata <= {temp_valid, 17'b0, temp_val};
                    2'd1: avs_readdata <= {29'b0, auto_en, fan_force, poll_en};
                    2'd2: avs_readdata <= {2'b0, off_th, 2'b0, on_th};
                    default: avs_readdata <= {16'b0, sample_cnt, 6'b0, fan_state, busy};
                endcase
            end

            if (avs_write) begin
                case (avs_address)
                    2'd1: begin
                        poll_en   <= avs_writedata[0];
                        fan_force <= avs_writedata[1];
                        auto_en   <= avs_writedata[2];
                    end
                    2'd2: begin
                        on_th  <= avs_writedata[13:0];
                        off_th <= avs_writedata[29:16];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_temp_fan_ctrl.sv
module tb_temp_fan_ctrl;

    localparam int CLK_DIV     = 2;
    localparam int POLL_CYCLES = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        temp_cs_n;
    logic        temp_sclk;
    logic        temp_din;
    logic        temp_dout;
    logic        fan_ctrl;

    temp_fan_ctrl #(.CLK_DIV(CLK_DIV), .POLL_CYCLES(POLL_CYCLES)) dut (
        .clk           (clk),
        .reset         (rst),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .temp_cs_n     (temp_cs_n),
        .temp_sclk     (temp_sclk),
        .temp_din      (temp_din),
        .temp_dout     (temp_dout),
        .fan_ctrl      (fan_ctrl)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Sensor model: word shifted out MSB first, next bit after each sclk rise.
    logic [15:0] sensor_word = 16'h0;
    logic [4:0]  bit_idx = 5'd0;
    always @(negedge temp_cs_n) bit_idx = 5'd0;
    always @(posedge temp_sclk) if (!temp_cs_n && bit_idx < 5'd16) bit_idx = bit_idx + 5'd1;
    assign temp_dout = (bit_idx < 5'd16) ? sensor_word[4'd15 - bit_idx[3:0]] : 1'b0;

    // Pin monitor, sampled mid-cycle.
    int cyc = 0;
    int first_fall = -1;
    int cs_falls = 0, cs_rises = 0, xfer_rise = 0, half_err = 0, run = 0;
    logic prev_cs = 1'b1, prev_sclk = 1'b1;
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;
    always @(negedge clk) begin
        if (temp_cs_n != prev_cs) begin
            if (!temp_cs_n) begin
                cs_falls++;
                xfer_rise = 0;
                if (first_fall < 0) first_fall = cyc;
            end else begin
                cs_rises++;
            end
        end
        if (temp_sclk != prev_sclk) begin
            if (!temp_cs_n && run != CLK_DIV) half_err++;
            if (temp_sclk && !temp_cs_n) xfer_rise++;
            run = 1;
        end else if (prev_cs && !temp_cs_n) begin
            run = 1;
        end else begin
            run++;
        end
        prev_cs   = temp_cs_n;
        prev_sclk = temp_sclk;
    end

    // Reference model of software-visible state.
    logic [2:0]  m_ctrl;
    logic [13:0] m_on, m_off, m_temp;
    logic        m_valid, m_fan;
    int          m_count;

    function automatic int s14(input logic [13:0] v);
        return v[13] ? int'(v) - 16384 : int'(v);
    endfunction

    function automatic logic model_fan(input logic cur, input logic [13:0] t,
                                       input logic [13:0] on, input logic [13:0] off,
                                       input logic auto);
        if (!auto) return cur;
        if (s14(t) >= s14(on)) return 1'b1;
        if (s14(t) <= s14(off)) return 1'b0;
        return cur;
    endfunction

    function automatic logic [31:0] exp_temp();
        return {m_valid, 17'b0, m_temp};
    endfunction

    function automatic logic [31:0] exp_status();
        return {16'b0, 8'(m_count), 6'b0, m_fan, 1'b0};
    endfunction

    function automatic logic exp_fan();
        return m_ctrl[1] | (m_ctrl[2] & m_fan);
    endfunction

    task automatic model_reset();
        m_ctrl = 3'h5; m_on = 14'h0A00; m_off = 14'h0780;
        m_temp = '0; m_valid = 1'b0; m_fan = 1'b1; m_count = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        avs_address = a; avs_read = 1'b1;
        tick();
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        tick();
        avs_write = 1'b0;
        if (a == 2'd1) m_ctrl = d[2:0];
        if (a == 2'd2) begin m_on = d[13:0]; m_off = d[29:16]; end
    endtask

    task automatic wait_cs_fall();
        int base = cs_falls;
        int n = 0;
        while (cs_falls == base && n < 400) begin tick(); n++; end
        if (cs_falls == base) begin
            n_tests++; n_fail++;
            $display("FAIL cs_fall_timeout: no cs_n fall within %0d cycles", n);
        end
    endtask

    task automatic finish_sample(input logic [15:0] w);
        int base = cs_rises;
        int n = 0;
        while (cs_rises == base && n < 3000) begin tick(); n++; end
        if (cs_rises == base) begin
            n_tests++; n_fail++;
            $display("FAIL xfer_timeout: no transfer end within %0d cycles", n);
        end
        m_count = (m_count + 1) % 256;
        m_temp  = w[13:0];
        m_valid = 1'b1;
        m_fan   = model_fan(m_fan, m_temp, m_on, m_off, m_ctrl[2]);
        repeat (3) tick();
    endtask

    task automatic sample(input logic [15:0] w);
        sensor_word = w;
        finish_sample(w);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1; avs_read = 1'b0; avs_write = 1'b0; avs_address = '0; avs_writedata = '0;
        sensor_word = 16'h0C80;
        repeat (3) tick();
        model_reset();
        first_fall = -1; half_err = 0;
        rst = 1'b0;
        n_tests++;
        if ({fan_ctrl, temp_cs_n, temp_sclk, temp_din} !== 4'b1110 || avs_readdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_pins: got fan/cs/sclk/din=%b rd=%h want 1110 rd=0",
                     {fan_ctrl, temp_cs_n, temp_sclk, temp_din}, avs_readdata);
        end
        bus_read(2'd1, d); n_tests++;
        if (d !== 32'h5) begin n_fail++; $display("FAIL reset_ctrl: got %h want 00000005", d); end
        bus_read(2'd2, d); n_tests++;
        if (d !== 32'h07800A00) begin n_fail++; $display("FAIL reset_thresh: got %h want 07800a00", d); end
        bus_read(2'd0, d); n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_temp: got %h want 0", d); end
        bus_read(2'd3, d); n_tests++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL reset_status: got %h want 00000002", d); end
        wait_cs_fall();
        n_tests++;
        if (first_fall != POLL_CYCLES) begin
            n_fail++; $display("FAIL first_cs_fall: got cycle %0d want %0d", first_fall, POLL_CYCLES);
        end
    endtask

    task automatic test_first_sample();
        logic [31:0] d;
        sample(16'h0C80);
        n_tests++;
        if (xfer_rise != 16 || half_err != 0) begin
            n_fail++; $display("FAIL sclk_shape: got rises=%0d half_err=%0d want 16/0", xfer_rise, half_err);
        end
        bus_read(2'd0, d); n_tests++;
        if (d !== 32'h80000C80) begin n_fail++; $display("FAIL first_temp: got %h want 80000c80", d); end
        bus_read(2'd3, d); n_tests++;
        if (d[15:8] !== 8'd1) begin n_fail++; $display("FAIL first_count: got %0d want 1", d[15:8]); end
        n_tests++;
        if (fan_ctrl !== 1'b1) begin n_fail++; $display("FAIL first_fan: got %b want 1", fan_ctrl); end
    endtask

    task automatic test_hysteresis();
        logic [15:0] words [5] = '{16'h0A00, 16'h0900, 16'h0780, 16'h0900, 16'h0A00};
        logic        seq   [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] d;
        for (int i = 0; i < 5; i++) begin
            sample(words[i]);
            bus_read(2'd3, d); n_tests++;
            if (d[1] !== seq[i] || d !== exp_status()) begin
                n_fail++; $display("FAIL hyst_status[%0d]: got %h want %h fan %b", i, d, exp_status(), seq[i]);
            end
            n_tests++;
            if (fan_ctrl !== exp_fan()) begin
                n_fail++; $display("FAIL hyst_fan[%0d]: got %b want %b", i, fan_ctrl, exp_fan());
            end
        end
    endtask

    task automatic test_negative();
        logic [31:0] d;
        sample(16'h3FE0);
        bus_read(2'd0, d); n_tests++;
        if (d !== 32'h80003FE0) begin n_fail++; $display("FAIL neg_temp: got %h want 80003fe0", d); end
        n_tests++;
        if (fan_ctrl !== 1'b0 || m_fan !== 1'b0) begin
            n_fail++; $display("FAIL neg_fan: got %b want 0", fan_ctrl);
        end
    endtask

    task automatic test_override();
        bus_write(2'd1, 32'h2);
        repeat (2) tick();
        n_tests++;
        if (fan_ctrl !== 1'b1) begin n_fail++; $display("FAIL force_on: got %b want 1", fan_ctrl); end
        bus_write(2'd1, 32'h0);
        repeat (2) tick();
        n_tests++;
        if (fan_ctrl !== 1'b0) begin n_fail++; $display("FAIL all_off: got %b want 0", fan_ctrl); end
    endtask

    task automatic test_poll_disable();
        logic [15:0] w = 16'($urandom);
        logic [31:0] d;
        int base;
        sensor_word = w;
        bus_write(2'd1, 32'h5);
        wait_cs_fall();
        repeat (10) tick();
        bus_write(2'd1, 32'h4);
        finish_sample(w);
        bus_read(2'd0, d); n_tests++;
        if (d !== exp_temp()) begin n_fail++; $display("FAIL stop_temp: got %h want %h", d, exp_temp()); end
        bus_read(2'd3, d); n_tests++;
        if (d !== exp_status()) begin n_fail++; $display("FAIL stop_status: got %h want %h", d, exp_status()); end
        base = cs_falls;
        repeat (3 * POLL_CYCLES) tick();
        n_tests++;
        if (cs_falls != base) begin
            n_fail++; $display("FAIL stop_no_poll: got %0d cs_n falls want 0", cs_falls - base);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [15:0] w = 16'($urandom);
        logic [31:0] d;
        int n = 0;
        sensor_word = w;
        bus_write(2'd1, 32'h5);
        wait_cs_fall();
        while (xfer_rise < 7 && n < 200) begin tick(); n++; end
        rst = 1'b1;
        tick();
        n_tests++;
        if (temp_cs_n !== 1'b1 || temp_sclk !== 1'b1) begin
            n_fail++; $display("FAIL midreset_pins: got cs=%b sclk=%b want 1/1", temp_cs_n, temp_sclk);
        end
        rst = 1'b0;
        model_reset();
        half_err = 0;
        bus_read(2'd0, d); n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL midreset_temp: got %h want 0", d); end
        w = 16'($urandom);
        sample(w);
        n_tests++;
        if (xfer_rise != 16 || half_err != 0) begin
            n_fail++; $display("FAIL midreset_xfer: got rises=%0d half_err=%0d want 16/0", xfer_rise, half_err);
        end
        bus_read(2'd0, d); n_tests++;
        if (d !== exp_temp()) begin n_fail++; $display("FAIL midreset_sample: got %h want %h", d, exp_temp()); end
        bus_read(2'd3, d); n_tests++;
        if (d !== exp_status()) begin n_fail++; $display("FAIL midreset_status: got %h want %h", d, exp_status()); end
    endtask

    task automatic test_random();
        logic [31:0] thr, ctl, d, old;
        // Same-cycle read and write of CTRL returns the pre-write value.
        old = {29'b0, m_ctrl};
        avs_address = 2'd1; avs_writedata = 32'h7; avs_read = 1'b1; avs_write = 1'b1;
        tick();
        avs_read = 1'b0; avs_write = 1'b0; m_ctrl = 3'h7;
        n_tests++;
        if (avs_readdata !== old) begin n_fail++; $display("FAIL rw_same: got %h want %h", avs_readdata, old); end
        for (int i = 0; i < 8; i++) begin
            thr = $urandom;
            ctl = $urandom | 32'h1;
            bus_write(2'd2, thr);
            bus_write(2'd1, ctl);
            bus_read(2'd2, d); n_tests++;
            if (d !== {2'b0, thr[29:16], 2'b0, thr[13:0]}) begin
                n_fail++; $display("FAIL rnd_thresh[%0d]: got %h want %h", i, d, {2'b0, thr[29:16], 2'b0, thr[13:0]});
            end
            bus_read(2'd1, d); n_tests++;
            if (d !== {29'b0, ctl[2:0]}) begin
                n_fail++; $display("FAIL rnd_ctrl[%0d]: got %h want %h", i, d, {29'b0, ctl[2:0]});
            end
            sample(16'($urandom));
            bus_read(2'd0, d); n_tests++;
            if (d !== exp_temp()) begin n_fail++; $display("FAIL rnd_temp[%0d]: got %h want %h", i, d, exp_temp()); end
            bus_read(2'd3, d); n_tests++;
            if (d !== exp_status()) begin n_fail++; $display("FAIL rnd_status[%0d]: got %h want %h", i, d, exp_status()); end
            n_tests++;
            if (fan_ctrl !== exp_fan()) begin n_fail++; $display("FAIL rnd_fan[%0d]: got %b want %b", i, fan_ctrl, exp_fan()); end
        end
    endtask

    initial begin
        test_reset();
        test_first_sample();
        test_hysteresis();
        test_negative();
        test_override();
        test_poll_disable();
        test_reset_mid_shift();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
